i2c_fifo_block: RTL and testbench
=================================

Name: i2c_fifo_block

Overview:
- Synchronous single-clock FIFO that buffers bytes between the host register interface and the I2C master core.
- Two instances are used:
  - Transmit FIFO: host writes, master core reads; drives data_i and trans_fifo_empty_i.
  - Receive FIFO: master core writes the received byte, host reads; drives rev_fifo_full_i.
- Provides full/empty/level status, programmable watermarks, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH = 16 entries.
- AFULL_LEVEL, 14, almost_full_o asserted when count_o >= AFULL_LEVEL.
- AEMPTY_LEVEL, 2, almost_empty_o asserted when count_o <= AEMPTY_LEVEL.

Ports:
- i2c_core_clock_i  in  1  core clock; all state changes on its rising edge.
- reset_bit_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush; highest priority after reset.
- wr_en_i  in  1  write request.
- wr_data_i  in  DATA_WIDTH  write data.
- rd_en_i  in  1  read request.
- rd_data_o  out  DATA_WIDTH  registered read data.
- rd_valid_o  out  1  one-cycle pulse; rd_data_o holds a newly popped word.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- almost_full_o  out  1  watermark flag.
- almost_empty_o  out  1  watermark flag.
- count_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky; set when a write is rejected.
- underflow_o  out  1  sticky; set when a read is rejected.
- err_clr_i  in  1  clears both sticky error flags.

Behaviour:
- Reset (reset_bit_i low, asynchronous):
  - Pointers = 0, count_o = 0, rd_data_o = 0, rd_valid_o = 0, overflow_o = 0, underflow_o = 0.
  - Therefore empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0.
  - Memory contents are not reset.
- Reset asserted mid-transfer: all in-flight requests are discarded; the FIFO restarts empty on the first edge after release.
- clear_i = 1 at an edge:
  - Pointers and count go to 0; rd_valid_o goes to 0.
  - wr_en_i/rd_en_i in the same cycle are ignored.
  - rd_data_o keeps its last value; sticky flags are unchanged.
- Write accepted = wr_en_i & (!full_o | rd_en_i):
  - Word stored at wr_ptr; wr_ptr increments modulo DEPTH.
- Read accepted = rd_en_i & !empty_o:
  - rd_data_o <= mem[rd_ptr] on the same edge; rd_ptr increments modulo DEPTH; rd_valid_o = 1 for that cycle only.
  - Latency: rd_en_i at edge N gives data valid after edge N, observable in cycle N+1.
- Count update: +1 on write only, -1 on read only, unchanged when both are accepted.
- Full with simultaneous read and write: both accepted, count stays DEPTH, no overflow.
- Empty with simultaneous read and write:
  - Write accepted, read rejected.
  - underflow_o set; no bypass of the incoming word; count becomes 1.
- Rejected write (wr_en_i & full_o & !rd_en_i): memory unchanged; overflow_o <= 1.
- Rejected read (rd_en_i & empty_o): rd_data_o holds; rd_valid_o = 0; underflow_o <= 1.
- Error flag update:
  - err_clr_i clears both sticky flags.
  - A new error event in the same cycle as err_clr_i wins; that flag is set.
- Status outputs:
  - full_o, empty_o, almost_full_o and almost_empty_o are combinational from registered count_o (no extra latency).
  - Pointer wrap 15 -> 0 must not disturb data order.
- No state machine beyond pointer/count control. Control priority: reset > clear_i > read/write.

Decomposition:
- Shared package i2c_pkg:
  - I2C_DATA_WIDTH = 8.
  - I2C_FIFO_ADDR_WIDTH = 4.
  - Default watermark constants.
- Sub-module i2c_fifo_mem:
  - Simple dual-port register array: one write port, one synchronous read port.
  - Holds storage only; all pointer, count and flag logic stays in i2c_fifo_block.

Test Plan:
- Reset then write 0x11..0x1F (15 words) -> count_o = 15, almost_full_o = 1, full_o = 0; one more write 0x20 -> full_o = 1, count_o = 16.
- Fill to 16, then write 0xAA with rd_en_i = 0 -> overflow_o = 1, count_o stays 16; drain all -> sequence 0x11..0x20 intact, rd_valid_o pulses 16 times, empty_o = 1.
- Full FIFO, rd_en_i = wr_en_i = 1 with 0x55 for 20 cycles -> count_o stays 16, no overflow, output order preserved across pointer wrap, 0x55 emerges after the 16 older words.
- Empty FIFO, rd_en_i = wr_en_i = 1 with 0x3C -> underflow_o = 1, rd_valid_o = 0, count_o = 1; next read returns 0x3C.
- Load 5 words, assert clear_i together with wr_en_i -> count_o = 0, empty_o = 1, written word discarded; err_clr_i together with a rejected read -> underflow_o remains 1.
- Assert reset_bit_i low between clock edges with 7 words stored -> empty_o = 1 and count_o = 0 immediately (asynchronous); after release, first write/read returns the new word.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C master byte FIFOs.
package i2c_pkg;

  localparam int I2C_DATA_WIDTH      = 8;
  localparam int I2C_FIFO_ADDR_WIDTH = 4;
  localparam int I2C_FIFO_AFULL      = 14;
  localparam int I2C_FIFO_AEMPTY     = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/i2c_fifo_block_if.sv
// Host/core-facing FIFO bus: request inputs, pop data, status and sticky error flags.
interface i2c_fifo_block_if
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int ADDR_WIDTH = I2C_FIFO_ADDR_WIDTH
);

  logic                  clear_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_en_i;
  logic                  err_clr_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output clear_i, wr_en_i, wr_data_i, rd_en_i, err_clr_i,
    input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  clear_i, wr_en_i, wr_data_i, rd_en_i, err_clr_i,
    output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/i2c_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
module i2c_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage itself is never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-during-write to the same address returns the old word, which is
  // exactly the oldest entry when a full FIFO pops and pushes together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/i2c_fifo_block.sv
// Single-clock byte FIFO with occupancy count, watermarks and sticky error flags.
module i2c_fifo_block
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH   = I2C_DATA_WIDTH,
  parameter int ADDR_WIDTH   = I2C_FIFO_ADDR_WIDTH,
  parameter int AFULL_LEVEL  = I2C_FIFO_AFULL,
  parameter int AEMPTY_LEVEL = I2C_FIFO_AEMPTY
) (
  input  logic             i2c_core_clock_i,
  input  logic             reset_bit_i,
  i2c_fifo_block_if.slave  fifo_if
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic                  ovf_evt, udf_evt;
  fifo_status_t          status;

  always_comb begin
    status.full         = (count_q == DEPTH_CNT);
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= AFULL_CNT);
    status.almost_empty = (count_q <= AEMPTY_CNT);
  end

  // A full FIFO still accepts a write when a read frees the slot on the same
  // edge; an empty FIFO never forwards the incoming word to the read side.
  assign rd_acc  = !fifo_if.clear_i & fifo_if.rd_en_i & !status.empty;
  assign wr_acc  = !fifo_if.clear_i & fifo_if.wr_en_i & (!status.full | fifo_if.rd_en_i);
  assign ovf_evt = !fifo_if.clear_i & fifo_if.wr_en_i & status.full & !fifo_if.rd_en_i;
  assign udf_evt = !fifo_if.clear_i & fifo_if.rd_en_i & status.empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (fifo_if.clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // A fresh error in the clearing cycle takes precedence over the clear.
      if (fifo_if.err_clr_i) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (ovf_evt) overflow_d  = 1'b1;
      if (udf_evt) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  i2c_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (i2c_core_clock_i),
    .rst_n   (reset_bit_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo_if.wr_data_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (fifo_if.rd_data_o)
  );

  assign fifo_if.rd_valid_o     = rd_valid_q;
  assign fifo_if.count_o        = count_q;
  assign fifo_if.full_o         = status.full;
  assign fifo_if.empty_o        = status.empty;
  assign fifo_if.almost_full_o  = status.almost_full;
  assign fifo_if.almost_empty_o = status.almost_empty;
  assign fifo_if.overflow_o     = overflow_q;
  assign fifo_if.underflow_o    = underflow_q;

endmodule

// File: tb/tb_i2c_fifo_block.sv
// Randomised and directed checks of i2c_fifo_block against a queue-based model.
module tb_i2c_fifo_block;
  import i2c_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  bit   verbose;

  logic [7:0] mq[$];
  logic [7:0] m_rdata;
  logic       m_rv;
  logic       m_ovf;
  logic       m_udf;

  i2c_fifo_block_if bus ();

  i2c_fifo_block dut (
    .i2c_core_clock_i (clk),
    .reset_bit_i      (rst_n),
    .fifo_if          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata = 8'h00;
    m_rv    = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // Behaviour as seen from outside: a bounded queue of 16 bytes.
  task automatic model_step(input logic wr, input logic rd, input logic clr,
                            input logic ec, input logic [7:0] d);
    int  n;
    bit  was_full, was_empty;
    n         = mq.size();
    was_full  = (n == 16);
    was_empty = (n == 0);
    if (clr) begin
      mq.delete();
      m_rv = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (rd && !was_empty) begin
        m_rdata = mq.pop_front();
        m_rv    = 1'b1;
      end
      if (wr && (!was_full || rd)) mq.push_back(d);
      if (ec) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (wr && was_full && !rd) m_ovf = 1'b1;
      if (rd && was_empty)       m_udf = 1'b1;
    end
  endtask

  task automatic compare_all();
    int n;
    n = mq.size();
    check("count",        32'(bus.count_o),        32'(n));
    check("full",         32'(bus.full_o),         32'(n == 16));
    check("empty",        32'(bus.empty_o),        32'(n == 0));
    check("almost_full",  32'(bus.almost_full_o),  32'(n >= 14));
    check("almost_empty", 32'(bus.almost_empty_o), 32'(n <= 2));
    check("rd_valid",     32'(bus.rd_valid_o),     32'(m_rv));
    check("rd_data",      32'(bus.rd_data_o),      32'(m_rdata));
    check("overflow",     32'(bus.overflow_o),     32'(m_ovf));
    check("underflow",    32'(bus.underflow_o),    32'(m_udf));
  endtask

  // Inputs change after the edge; outputs are sampled 1 time unit after it.
  task automatic cyc(input logic wr, input logic rd, input logic clr,
                     input logic ec, input logic [7:0] d);
    bus.wr_en_i   = wr;
    bus.rd_en_i   = rd;
    bus.clear_i   = clr;
    bus.err_clr_i = ec;
    bus.wr_data_i = d;
    @(posedge clk);
    model_step(wr, rd, clr, ec, d);
    #1;
    compare_all();
    if (verbose)
      $display("t=%0t wr=%b rd=%b clr=%b ec=%b din=%02h -> dout=%02h v=%b cnt=%0d ovf=%b udf=%b",
               $time, wr, rd, clr, ec, d, bus.rd_data_o, bus.rd_valid_o,
               bus.count_o, bus.overflow_o, bus.underflow_o);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int pulses;
    int pw, pr;
    logic [7:0] rv;

    vectors     = 0;
    miscompares = 0;
    verbose     = 1'b1;
    bus.wr_en_i   = 1'b0;
    bus.rd_en_i   = 1'b0;
    bus.clear_i   = 1'b0;
    bus.err_clr_i = 1'b0;
    bus.wr_data_i = 8'h00;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Fill to 15, then 16.
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h11 + i));
    check("fill15_count", 32'(bus.count_o), 32'd15);
    check("fill15_afull", 32'(bus.almost_full_o), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
    check("fill16_full", 32'(bus.full_o), 32'd1);

    // Overflow, then drain with order check.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
    check("ovf_set", 32'(bus.overflow_o), 32'd1);
    check("ovf_count", 32'(bus.count_o), 32'd16);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      pulses += int'(bus.rd_valid_o);
      check("drain_seq", 32'(bus.rd_data_o), 32'(8'h11 + i));
    end
    check("drain_pulses", 32'(pulses), 32'd16);
    idle();
    check("drain_empty", 32'(bus.empty_o), 32'd1);

    // Full with simultaneous read/write across pointer wrap.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    check("rw_full_count", 32'(bus.count_o), 32'd16);
    check("rw_full_noovf", 32'(bus.overflow_o), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("wrap_last", 32'(bus.rd_data_o), 32'h55);

    // Empty with simultaneous read/write: no bypass.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    check("empty_rw_udf", 32'(bus.underflow_o), 32'd1);
    check("empty_rw_valid", 32'(bus.rd_valid_o), 32'd0);
    check("empty_rw_count", 32'(bus.count_o), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("empty_rw_data", 32'(bus.rd_data_o), 32'h3C);

    // Clear beats a same-cycle write; new error wins over err_clr.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
    check("clr_count", 32'(bus.count_o), 32'd0);
    check("clr_empty", 32'(bus.empty_o), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check("errclr_vs_udf", 32'(bus.underflow_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // Randomised traffic with varying fill bias.
    verbose = 1'b0;
    for (int blk = 0; blk < 6; blk++) begin
      pw = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 30 : 55);
      pr = 100 - pw;
      for (int i = 0; i < 400; i++)
        cyc(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
            1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 29) == 0),
            8'($urandom));
    end
    verbose = 1'b1;

    // Asynchronous reset between edges with 7 words stored.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_empty", 32'(bus.empty_o), 32'd1);
    check("async_count", 32'(bus.count_o), 32'd0);
    compare_all();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    rv = bus.rd_data_o;
    check("post_reset_data", 32'(rv), 32'h77);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
